lint_datapath_arbiter: RTL and testbench
========================================

Name: lint_datapath_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit registered output stage between three requesters with 2-, 3- and 4-bit data inputs.
- Sits between the lint-lab input channels (Data_in1/2/3 class sources) and a single downstream consumer.
- Grants one requester at a time, allows bounded bursts, and applies valid/ready backpressure.
- The global enable `check` gates new grants.

Parameters:
- MAX_BURST, 4: maximum accepted beats per grant before the grant is forcibly released (legal range 1..15).
- DATA_W, 4: output data width; must be >= 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- check  in  1  arbitration enable; 0 blocks new grants and releases any current grant.
- req  in  3  request per requester; bit i belongs to requester i.
- data1  in  2  requester 0 payload; zero-extended to DATA_W.
- data2  in  3  requester 1 payload; zero-extended to DATA_W.
- data3  in  4  requester 2 payload; zero-extended to DATA_W.
- gnt  out  3  registered one-hot grant; all zeros when idle.
- ack  out  3  combinational beat-accept strobe per requester.
- out_valid  out  1  output stage holds a beat.
- out_data  out  DATA_W  output payload.
- out_src  out  2  index of the requester that produced out_data (0..2).
- out_ready  in  1  consumer accepts the output beat this cycle.

Behaviour:
- Reset (reset=1 at a clock edge):
  - gnt=0, out_valid=0, out_data=0, out_src=0.
  - State goes to IDLE, beat_cnt=0, last_grant=2 (so requester 0 has first priority).
  - Any in-flight beat is discarded. Reset overrides every other event in the same cycle.
- Stage free: stage_free = !out_valid | out_ready.
- Beat acceptance: ack[i] = gnt[i] & req[i] & stage_free. At most one ack bit is high.
- On any ack:
  - Next cycle out_valid=1.
  - out_data = the granted payload, zero-extended.
  - out_src = the granted index.
- Output drain: out_valid & out_ready with no ack in the same cycle clears out_valid next cycle; out_data/out_src keep their value. Load and drain in the same cycle are a pass-through: the new beat replaces the old one with no bubble.
- While out_valid=1 & out_ready=0: out_data and out_src remain stable.
- State IDLE (gnt=0):
  - If check=1 & |req: the winner is the first requester with req set, searching from (last_grant+1) mod 3 upward with wrap.
  - Next cycle: gnt=onehot(winner), state GRANT, beat_cnt=0.
  - Otherwise stay in IDLE.
- State GRANT (gnt[g]=1):
  - Each ack increments beat_cnt.
  - The grant is released (next cycle gnt=0, state IDLE, last_grant=g) when any of these holds:
    - req[g]=0;
    - ack with beat_cnt==MAX_BURST-1 (the burst is complete);
    - check=0.
  - An ack in the release cycle still counts and is loaded.
  - Backpressure (stage not free) holds the grant; beat_cnt does not advance.
- Latency and throughput:
  - req rising edge in IDLE to gnt: 1 cycle.
  - Earliest ack is in the gnt cycle; data appears on out_* 1 cycle after ack.
  - Back-to-back beats run at one per cycle while out_ready=1.
  - A release costs one idle cycle before the next grant.
- Fairness: with all requesters continuously active, the grant order is 0,1,2,0,... with exactly MAX_BURST beats each.
- check=0 in IDLE: no grant, even with req pending. The output stage still drains.
- Requesters must hold their data stable while req=1 and no ack has been received.

Test Plan:
- Reset, then req=3'b001, data1=2'b11, out_ready=1 -> gnt=3'b001 after 1 cycle, ack[0] in the same cycle, next cycle out_valid=1, out_data=4'b0011, out_src=0.
- req=3'b111 held, out_ready=1, MAX_BURST=4 -> gnt sequence 001 (4 acks), idle cycle, 010 (4 acks), idle cycle, 100 (4 acks), then 001 again.
- Requester 1 granted, data2=3'b101, out_ready=0 for 3 cycles -> one beat stored (out_data=4'b0101, out_src=1) and stable; ack=0 and beat_cnt frozen; the beat is released on the first cycle out_ready=1.
- check=0 with req=3'b100 -> gnt stays 0 and out_valid stays 0. Raise check -> gnt=3'b100 the next cycle. Drop check mid-burst -> gnt=0 the next cycle.
- Mid-burst (beat_cnt=2, out_valid=1), assert reset for 1 cycle -> gnt=0, out_valid=0, out_data=0. Then with req=3'b110 -> the first grant goes to requester 1 (last_grant=2 after reset).
- Granted requester drops req after 1 beat while req[2]=1 -> gnt=0 for one cycle, then gnt=3'b100.

Source files
------------

// File: rtl/lint_datapath_arbiter.sv
// rtl/lint_datapath_arbiter.sv - round-robin arbiter sharing one registered output stage between three requesters
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   check      in   arbitration enable; low blocks new grants and releases the current one
//   req[2:0]   in   per-requester request
//   data1[1:0] in   requester 0 payload (zero-extended)
//   data2[2:0] in   requester 1 payload (zero-extended)
//   data3[3:0] in   requester 2 payload (zero-extended)
//   gnt[2:0]   out  registered one-hot grant, zero when idle
//   ack[2:0]   out  combinational beat-accept strobe
//   out_valid  out  output stage holds a beat
//   out_data   out  output payload
//   out_src    out  index of the requester that produced out_data
//   out_ready  in   consumer accepts the output beat this cycle
module lint_datapath_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int DATA_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              check,
    input  logic [2:0]        req,
    input  logic [1:0]        data1,
    input  logic [2:0]        data2,
    input  logic [3:0]        data3,
    output logic [2:0]        gnt,
    output logic [2:0]        ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    input  logic              out_ready
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;

    logic        stage_free;
    logic        ack_any;
    logic        release_now;
    logic [1:0]  g_idx;
    logic [1:0]  cand0, cand1, cand2;
    logic [1:0]  winner;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            cnt_q   <= 4'd0;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Round-robin search order starts just after the last released requester
    always_comb begin
        cand0  = next3(last_q);
        cand1  = next3(cand0);
        cand2  = next3(cand1);
        winner = cand0;
        if (req[cand0])      winner = cand0;
        else if (req[cand1]) winner = cand1;
        else if (req[cand2]) winner = cand2;
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (check && (|req)) begin
                    state_d = GRANT;
                    gnt_d   = 3'b001 << winner;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                release_now = !req[g_idx] || !check ||
                              (ack_any && (cnt_q == 4'(MAX_BURST - 1)));
                if (ack_any) cnt_d = cnt_q + 4'd1;
                if (release_now) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    cnt_d   = 4'd0;
                    last_d  = g_idx;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // Output logic: grant decode, accept strobe and payload select
    always_comb begin
        g_idx      = gnt_q[2] ? 2'd2 : (gnt_q[1] ? 2'd1 : 2'd0);
        stage_free = !out_valid || out_ready;
        ack        = gnt_q & req & {3{stage_free}};
        ack_any    = |ack;
        gnt        = gnt_q;
        case (g_idx)
            2'd0:    sel_data = DATA_W'(data1);
            2'd1:    sel_data = DATA_W'(data2);
            default: sel_data = DATA_W'(data3);
        endcase
    end

    // Output stage: a load in the same cycle as a drain replaces the beat without a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (ack_any) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= g_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lint_datapath_arbiter.sv
// tb/tb_lint_datapath_arbiter.sv - self-checking bench for lint_datapath_arbiter against a behavioural model
module tb_lint_datapath_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       check;
    logic [2:0] req;
    logic [1:0] data1;
    logic [2:0] data2;
    logic [3:0] data3;
    logic [2:0] gnt;
    logic [2:0] ack;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    // Model: granted requester (-1 when idle), beats taken in this grant, last released requester
    int         m_g;
    int         m_cnt;
    int         m_last;
    logic       m_valid;
    logic [3:0] m_data;
    logic [1:0] m_src;

    lint_datapath_arbiter #(.MAX_BURST(MAX_BURST), .DATA_W(4)) dut (
        .clk(clk), .reset(reset), .check(check), .req(req),
        .data1(data1), .data2(data2), .data3(data3),
        .gnt(gnt), .ack(ack), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] payload(input int i);
        case (i)
            0:       return {2'b00, data1};
            1:       return {1'b0, data2};
            default: return data3;
        endcase
    endfunction

    task automatic model_reset();
        m_g = -1; m_cnt = 0; m_last = 2;
        m_valid = 1'b0; m_data = 4'd0; m_src = 2'd0;
    endtask

    // Compare DUT against the model for the current cycle, then advance one clock
    task automatic tick();
        logic [2:0] exp_gnt;
        logic [2:0] exp_ack;
        bit         free;
        bit         a;
        bit         done;
        bit         found;
        int         c;
        #2;
        exp_gnt = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
        free    = !m_valid || out_ready;
        exp_ack = 3'b000;
        if (m_g >= 0 && req[m_g] && free) exp_ack[m_g] = 1'b1;
        chk("gnt", 8'(gnt), 8'(exp_gnt));
        chk("ack", 8'(ack), 8'(exp_ack));
        chk("out_valid", 8'(out_valid), 8'(m_valid));
        chk("out_data", 8'(out_data), 8'(m_data));
        chk("out_src", 8'(out_src), 8'(m_src));
        if (reset) begin
            model_reset();
        end else begin
            a = (exp_ack != 3'b000);
            if (a) begin
                m_valid = 1'b1;
                m_data  = payload(m_g);
                m_src   = 2'(m_g);
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (m_g < 0) begin
                if (check && req != 3'b000) begin
                    found = 0;
                    for (int k = 1; k <= 3; k++) begin
                        c = (m_last + k) % 3;
                        if (!found && req[c]) begin
                            m_g = c;
                            found = 1;
                        end
                    end
                    m_cnt = 0;
                end
            end else begin
                done = a && (m_cnt == MAX_BURST - 1);
                if (a) m_cnt++;
                if (!req[m_g] || done || !check) begin
                    m_last = m_g;
                    m_g    = -1;
                    m_cnt  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; check = 1'b1; req = 3'b000; out_ready = 1'b1;
        data1 = 2'd0; data2 = 3'd0; data3 = 4'd0;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        tick();
        chk("reset_gnt", 8'(gnt), 8'h00);

        // Single beat from requester 0
        reset = 1'b0; req = 3'b001; data1 = 2'b11;
        tick();
        chk("t1_gnt", 8'(gnt), 8'h01);
        tick();
        chk("t1_valid", 8'(out_valid), 8'h01);
        chk("t1_data", 8'(out_data), 8'h03);
        chk("t1_src", 8'(out_src), 8'h00);
        req = 3'b000;
        repeat (3) tick();

        // Fairness with all requesters active
        req = 3'b111; data1 = 2'd1; data2 = 3'd6; data3 = 4'd9;
        repeat (24) tick();
        req = 3'b000;
        repeat (3) tick();

        // Backpressure on requester 1
        reset = 1'b1; tick(); reset = 1'b0;
        req = 3'b010; data2 = 3'b101; out_ready = 1'b0;
        repeat (4) tick();
        chk("bp_data", 8'(out_data), 8'h05);
        chk("bp_src", 8'(out_src), 8'h01);
        out_ready = 1'b1;
        repeat (3) tick();
        req = 3'b000;
        repeat (2) tick();

        // check gating
        check = 1'b0; req = 3'b100; data3 = 4'hA;
        repeat (3) tick();
        check = 1'b1;
        repeat (3) tick();
        check = 1'b0;
        repeat (2) tick();
        check = 1'b1; req = 3'b000;
        repeat (2) tick();

        // Reset mid-burst, then round-robin restart
        req = 3'b001; data1 = 2'd2;
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_reset_valid", 8'(out_valid), 8'h00);
        req = 3'b110;
        tick();
        chk("rr_after_reset", 8'(gnt), 8'h02);
        repeat (2) tick();

        // Early drop of the granted requester hands over after one idle cycle
        req = 3'b100;
        repeat (3) tick();
        req = 3'b000;
        repeat (2) tick();
        req = 3'b101;
        repeat (2) tick();
        req = 3'b100;
        repeat (4) tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            check     = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 59) == 0);
            data1     = 2'($urandom);
            data2     = 3'($urandom);
            data3     = 4'($urandom);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
